// File: rtl/overlay_pkg.sv
// Shared constants and fetch-FSM encoding for the text overlay renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   COLS_DEF / ROWS_DEF : default text grid size (40 x 30 cells)
//   CELL_PX             : cell edge in pixels (cells are CELL_PX x CELL_PX)
//   fetch_state_t       : glyph fetch FSM states
package overlay_pkg;

  localparam int COLS_DEF = 40;
  localparam int ROWS_DEF = 30;
  localparam int CELL_PX  = 8;

  // IDLE waits for a trigger; every other state lasts exactly one i_clk.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IDX   = 3'd1,
    IDX_W = 3'd2,
    GLY   = 3'd3,
    GLY_W = 3'd4,
    LOAD  = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/overlay_glyph_fetch.sv
// Fetches one glyph row: character index RAM, then font ROM, into next_bits.
// Latency: next_bits updated 5 i_clk after the trigger edge.
// Backpressure: none; triggers arriving while busy are ignored.
//
// Ports:
//   i_clk, reset          : clock, synchronous active-high reset
//   trigger, col, y       : start a fetch of cell column col on text line y
//   chram_addr/chmap_data : character index RAM (1-clock read latency)
//   chrom_addr/chrom_data : font ROM {code, glyph_row} (1-clock read latency)
//   next_bits             : glyph row for the upcoming cell, bit7 leftmost
//   busy                  : FSM is not IDLE
module overlay_glyph_fetch
  import overlay_pkg::*;
#(
  parameter int COLS = COLS_DEF
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [6:0]  col,
  input  logic [9:0]  y,
  output logic [10:0] chram_addr,
  input  logic [7:0]  chmap_data,
  output logic [10:0] chrom_addr,
  input  logic [7:0]  chrom_data,
  output logic [7:0]  next_bits,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  fetch_state_t state;
  logic [7:0]   code;
  logic [2:0]   glyph_row;
  logic [10:0]  cell_addr;

  // Row-major index of the cell: (text row) * COLS + column.
  assign cell_addr = 11'(32'(y[9:3]) * 32'(COLS) + 32'(col));
  assign busy      = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state      <= IDLE;
      chram_addr <= '0;
      chrom_addr <= '0;
      next_bits  <= '0;
      code       <= '0;
      glyph_row  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            // The trigger at the start of the last cell asks for a column
            // past the right edge: blank the pipeline instead of fetching.
            if (col > LAST_COL) begin
              next_bits <= '0;
            end else begin
              chram_addr <= cell_addr;
              glyph_row  <= y[2:0];
              state      <= IDX;
            end
          end
        end
        // Index RAM samples chram_addr on this edge.
        IDX:   state <= IDX_W;
        IDX_W: begin
          code  <= chmap_data;
          state <= GLY;
        end
        GLY: begin
          chrom_addr <= {code, glyph_row};
          state      <= GLY_W;
        end
        // Font ROM samples chrom_addr on this edge.
        GLY_W: state <= LOAD;
        LOAD: begin
          next_bits <= chrom_data;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/overlay_text_render.sv
// Text overlay: turns a character grid plus font ROM into a per-pixel alpha.
// Latency: a is registered 1 i_clk after the ce_pix edge carrying hcnt/vcnt.
// Backpressure: none; free-running pixel pipeline, glyph fetch runs a cell ahead.
//
// Ports:
//   i_clk, reset          : clock, synchronous active-high reset
//   ce_pix                : pixel enable (at most every 2nd i_clk)
//   hcnt, vcnt            : current pixel position
//   chram_addr/chmap_data : character index RAM read port
//   chrom_addr/chrom_data : font ROM read port
//   a                     : overlay alpha for the current pixel
// Build option: define OVL_BOLD_EN for 1-pixel horizontal emboldening.
module overlay_text_render
  import overlay_pkg::*;
#(
  parameter int         COLS     = COLS_DEF,
  parameter int         ROWS     = ROWS_DEF,
  parameter logic [9:0] X_ORIGIN = 10'd0,
  parameter logic [9:0] Y_ORIGIN = 10'd0
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  output logic [10:0] chram_addr,
  input  logic [7:0]  chmap_data,
  output logic [10:0] chrom_addr,
  input  logic [7:0]  chrom_data,
  output logic        a
);

  localparam logic [10:0] AREA_W = 11'(CELL_PX * COLS);
  localparam logic [10:0] AREA_H = 11'(CELL_PX * ROWS);

  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] x_next_cell;
  logic       x_in;
  logic       y_in;
  logic       in_area;
  logic       cell_start;
  logic       fetch_trig;
  logic       fetch_busy;
  logic [6:0] fetch_col;
  logic [7:0] next_bits;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;
  logic       a_nxt;

  // Text-relative coordinates; wrap mod 1024 so the column-0 fetch happens
  // at x = 1016, one cell before the first text pixel.
  assign x           = hcnt - X_ORIGIN;
  assign y           = vcnt - Y_ORIGIN;
  assign x_next_cell = x + 10'(CELL_PX);

  assign x_in       = ({1'b0, x} < AREA_W);
  assign y_in       = ({1'b0, y} < AREA_H);
  assign in_area    = x_in & y_in;
  assign cell_start = (x[2:0] == 3'd0);

  // At each cell start, fetch the following cell. Column COLS is still
  // triggered so the fetcher can blank next_bits past the right edge.
  assign fetch_col  = x_next_cell[9:3];
  assign fetch_trig = ce_pix & y_in & cell_start & ~fetch_busy &
                      ({1'b0, x_next_cell} <= AREA_W);

  overlay_glyph_fetch #(
    .COLS (COLS)
  ) u_fetch (
    .i_clk      (i_clk),
    .reset      (reset),
    .trigger    (fetch_trig),
    .col        (fetch_col),
    .y          (y),
    .chram_addr (chram_addr),
    .chmap_data (chmap_data),
    .chrom_addr (chrom_addr),
    .chrom_data (chrom_data),
    .next_bits  (next_bits),
    .busy       (fetch_busy)
  );

  assign shreg_nxt = (x_in && cell_start) ? next_bits : {shreg[6:0], 1'b0};

`ifdef OVL_BOLD_EN
  // MSB of the previous pixel, zero outside the text area; the left edge
  // (x == 0) never inherits a pixel from outside the area.
  logic prev_msb;

  assign a_nxt = in_area & (shreg_nxt[7] | (prev_msb & (x != 10'd0)));

  always_ff @(posedge i_clk) begin
    if (reset) begin
      prev_msb <= 1'b0;
    end else if (ce_pix) begin
      prev_msb <= in_area & shreg_nxt[7];
    end
  end
`else
  assign a_nxt = in_area & shreg_nxt[7];
`endif

  always_ff @(posedge i_clk) begin
    if (reset) begin
      shreg <= '0;
      a     <= 1'b0;
    end else if (ce_pix) begin
      shreg <= shreg_nxt;
      a     <= a_nxt;
    end
  end

endmodule
